lsu: RTL

Load/store unit between the pipeline's memory stage and the single-port word-addressed data memory `mem`. Accepts one byte/halfword/word load or store per handshake, converts byte addresses to word indices, extracts and sign/zero-extends load data, and implements sub-word stores as a read-modify-write, since `mem` has no byte enables. Reports bad requests (out-of-range, reserved size, optionally misaligned) as errors without touching memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/lsu.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and default memory depth.
package lsu_pkg;

  localparam int LSU_MEM_WORDS = 128;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data from a memory word and
// builds the read-modify-write word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    w_byte       = i_mem_word[7:0];
    w_half       = i_mem_word[15:0];
    o_load_data  = i_mem_word;
    o_merge_word = i_mem_word;

    case (i_lane)
      2'd1:    w_byte = i_mem_word[15:8];
      2'd2:    w_byte = i_mem_word[23:16];
      2'd3:    w_byte = i_mem_word[31:24];
      default: w_byte = i_mem_word[7:0];
    endcase

    // Halfwords select on addr[1] only; addr[0] is either trapped upstream or ignored.
    if (i_lane[1]) w_half = i_mem_word[31:16];

    case (i_size)
      SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load_data = i_mem_word;
    endcase

    case (i_size)
      SZ_BYTE: begin
        case (i_lane)
          2'd1:    o_merge_word[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_word[23:16] = i_wdata[7:0];
          2'd3:    o_merge_word[31:24] = i_wdata[7:0];
          default: o_merge_word[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (i_lane[1]) o_merge_word[31:16] = i_wdata[15:0];
        else           o_merge_word[15:0]  = i_wdata[15:0];
      end
      default: o_merge_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM between the memory stage and a single-port word memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ma,
  output logic [31:0] mwd,
  output logic        mwr,
  output logic        moe,
  input  logic [31:0] mrd
);

  localparam logic [29:0] INDEX_LIMIT = 30'(MEM_WORDS);

  lsu_state_e  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;
  logic [31:0] r_ma;
  logic [31:0] r_mwd;
  logic        r_mwr;
  logic        r_moe;

  logic        w_range_err;
  logic        w_misalign;
  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_word;

  // Full upper address is compared so out-of-range indices never wrap into memory.
  assign w_range_err = (req_addr[31:2] >= INDEX_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = (req_size == SZ_RSVD) || w_range_err || w_misalign;

  lsu_lane_align u_lane_align (
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_lane       (r_lane),
    .i_mem_word   (mrd),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_word (w_merge_word)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 32'h0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'h0;
      r_ma         <= 32'h0;
      r_mwd        <= 32'h0;
      r_mwr        <= 1'b0;
      r_moe        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_signed   <= req_signed;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_ready    <= 1'b0;
            r_rdata    <= 32'h0;
            r_resp_err <= 1'b0;
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_ma    <= {2'b00, req_addr[31:2]};
              r_state <= ST_ACCESS;
              if (req_we && (req_size == SZ_WORD)) begin
                r_mwr <= 1'b1;
                r_mwd <= req_wdata;
              end else begin
                r_moe <= 1'b1;
              end
            end
          end
        end

        ST_ACCESS: begin
          r_moe <= 1'b0;
          r_mwr <= 1'b0;
          if (!r_we) begin
            r_rdata      <= w_load_data;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_size == SZ_WORD) begin
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            // The write-data register doubles as the merge register: it captures the
            // read word with the target lane already replaced.
            r_mwd   <= w_merge_word;
            r_mwr   <= 1'b1;
            r_state <= ST_MERGE;
          end
        end

        ST_MERGE: begin
          r_mwr        <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end

        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_rdata      <= 32'h0;
          r_ready      <= 1'b1;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rdata;
  assign ma         = r_ma;
  assign mwd        = r_mwd;
  assign mwr        = r_mwr;
  assign moe        = r_moe;

endmodule
